// File: rtl/fht_pkg.sv
// Shared types and address helpers for the 4-bank radix-2 FHT sequencer.
// Address helpers work on 16-bit values; callers truncate to their bank address width.
package fht_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fht_state_t;

    localparam int LOG2N_MIN = 3;

    function automatic logic [3:0] clamp_log2n(input logic [3:0] req, input logic [3:0] max_l);
        if (req < 4'(LOG2N_MIN)) return 4'(LOG2N_MIN);
        if (req > max_l) return max_l;
        return req;
    endfunction

    // Hartley mirror inside each block of sub = 2^(s-1) entries; identity for s < 2.
    function automatic logic [15:0] mirror_addr(input logic [15:0] cnt, input logic [3:0] s);
        logic [15:0] sub;
        logic [15:0] msk;
        sub = 16'd1 << (s - 4'd1);
        msk = sub - 16'd1;
        if (s < 4'd2) return cnt;
        return (cnt & ~msk) | ((sub - (cnt & msk)) & msk);
    endfunction

    function automatic logic [15:0] coef_addr(input logic [15:0] cnt, input logic [3:0] s,
                                              input logic [3:0] max_l);
        logic [15:0] msk;
        msk = (16'd1 << (s - 4'd1)) - 16'd1;
        if (s < 4'd2) return 16'd0;
        return (cnt & msk) << (max_l - 4'd1 - s);
    endfunction

endpackage

// File: rtl/fht_delay_line.sv
// Fixed-depth shift register carrying the read address pair and valid bit to the write side.
// Shifting stops while iEN is low; iCLEAR zeroes every stage on the next edge.
module fht_delay_line #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 3
) (
    input  logic             iCLK,
    input  logic             iCLEAR,
    input  logic             iEN,
    input  logic [WIDTH-1:0] iD,
    output logic [WIDTH-1:0] oQ
);

    logic [WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge iCLK) begin
        if (iCLEAR) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else if (iEN) begin
            pipe[0] <= iD;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign oQ = pipe[DEPTH-1];

endmodule

// File: rtl/fht_control_gen.sv
// Stage/address sequencer for the 4-bank radix-2 FHT core with stall and drain handling.
//   state    | meaning
//   ST_IDLE  | waiting for iSTART, oRDY high
//   ST_RUN   | issuing one read pair per cycle, cnt 0..D-1
//   ST_DRAIN | PIPE_LAT cycles letting the butterfly pipeline write back
//   ST_DONE  | one-cycle completion, oDONE pulse
module fht_control_gen
    import fht_pkg::*;
#(
    parameter int LOG2N_MAX = 10,
    parameter int PIPE_LAT  = 3,
    parameter int A_BIT     = LOG2N_MAX - 2
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iSTART,
    input  logic [3:0]       iLOG2N,
    input  logic             iHOLD,
    output logic             oRDY,
    output logic             oDONE,
    output logic [3:0]       oSTAGE,
    output logic             oST_ZERO,
    output logic             oST_LAST,
    output logic [A_BIT-1:0] oADDR_RD_A,
    output logic [A_BIT-1:0] oADDR_RD_B,
    output logic [A_BIT-1:0] oADDR_WR_A,
    output logic [A_BIT-1:0] oADDR_WR_B,
    output logic [A_BIT-1:0] oADDR_COEF,
    output logic             oRD_VALID,
    output logic             oWE_A,
    output logic             oWE_B,
    output logic             oSOURCE_DATA
);

    localparam logic [3:0] L_MAX      = 4'(LOG2N_MAX);
    localparam logic [3:0] DRAIN_LOAD = 4'(PIPE_LAT - 1);
    localparam int         DW         = 2 * A_BIT + 1;

    fht_state_t       state, state_nxt;
    logic [A_BIT-1:0] cnt, cnt_nxt, cnt_last;
    logic [3:0]       stage, stage_nxt, len_l, len_nxt, drain, drain_nxt;
    logic             source, source_nxt;
    logic             running, rd_valid, wr_valid, wr_en;
    logic [A_BIT-1:0] rd_a, rd_b, coef;
    logic [DW-1:0]    dl_in, dl_out;

    assign cnt_last = A_BIT'((32'd1 << (len_l - 4'd2)) - 32'd1);

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            stage  <= '0;
            len_l  <= 4'(LOG2N_MIN);
            drain  <= '0;
            source <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            stage  <= stage_nxt;
            len_l  <= len_nxt;
            drain  <= drain_nxt;
            source <= source_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        stage_nxt  = stage;
        len_nxt    = len_l;
        drain_nxt  = drain;
        source_nxt = source;
        case (state)
            ST_IDLE: begin
                if (iSTART) begin
                    state_nxt  = ST_RUN;
                    cnt_nxt    = '0;
                    stage_nxt  = '0;
                    len_nxt    = clamp_log2n(iLOG2N, L_MAX);
                    source_nxt = 1'b0;
                end
            end
            ST_RUN: begin
                if (!iHOLD) begin
                    if (cnt == cnt_last) begin
                        state_nxt = ST_DRAIN;
                        drain_nxt = DRAIN_LOAD;
                    end else begin
                        cnt_nxt = cnt + A_BIT'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (!iHOLD) begin
                    if (drain != 4'd0) begin
                        drain_nxt = drain - 4'd1;
                    end else if (stage == len_l - 4'd1) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt  = ST_RUN;
                        stage_nxt  = stage + 4'd1;
                        cnt_nxt    = '0;
                        source_nxt = !source;
                    end
                end
            end
            ST_DONE: begin
                if (!iHOLD) begin
                    state_nxt = ST_IDLE;
                    stage_nxt = '0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Read-side addresses are zero outside RUN so idle entries in the delay line carry zeros.
    assign running  = (state == ST_RUN) || (state == ST_DRAIN);
    assign rd_valid = (state == ST_RUN) && !iHOLD;
    assign rd_a     = (state == ST_RUN) ? cnt : '0;
    assign rd_b     = (state == ST_RUN) ? A_BIT'(mirror_addr(16'(cnt), stage)) : '0;
    assign coef     = (state == ST_RUN) ? A_BIT'(coef_addr(16'(cnt), stage, L_MAX)) : '0;
    assign dl_in    = {rd_valid, rd_a, rd_b};

    fht_delay_line #(
        .WIDTH (DW),
        .DEPTH (PIPE_LAT)
    ) u_delay (
        .iCLK   (iCLK),
        .iCLEAR (iRESET),
        .iEN    (!iHOLD),
        .iD     (dl_in),
        .oQ     (dl_out)
    );

    assign wr_valid = dl_out[DW-1];
    assign wr_en    = wr_valid && !iHOLD;

    assign oRDY         = (state == ST_IDLE) || (state == ST_DONE);
    assign oDONE        = (state == ST_DONE) && !iHOLD;
    assign oSTAGE       = stage;
    assign oST_ZERO     = running && (stage == 4'd0);
    assign oST_LAST     = running && (stage == len_l - 4'd1);
    assign oADDR_RD_A   = rd_a;
    assign oADDR_RD_B   = rd_b;
    assign oADDR_COEF   = coef;
    assign oRD_VALID    = rd_valid;
    assign oADDR_WR_A   = wr_valid ? dl_out[2*A_BIT-1:A_BIT] : '0;
    assign oADDR_WR_B   = wr_valid ? dl_out[A_BIT-1:0] : '0;
    assign oWE_A        = wr_en && stage[0];
    assign oWE_B        = wr_en && !stage[0];
    assign oSOURCE_DATA = source;

endmodule

// File: doc/fht_control_gen.md
Name: fht_control_gen

Overview:
- Parametrised successor sequencer for the 4-bank radix-2 FHT core.
- Generates per-stage read, write and coefficient addresses, bank write enables and data-source select for any transform length 2^3..2^LOG2N_MAX, selected at run time.
- Adds a stall input, a configurable butterfly pipeline latency and a one-cycle completion pulse.
- Sits between the host start logic and the bank mixers and coefficient ROM.

Parameters:
- LOG2N_MAX, 10, log2 of the largest supported transform length.
- PIPE_LAT, 3, cycles from read address issue to write of the same butterfly result (1..15).
- A_BIT, LOG2N_MAX-2, bank address width (depth per bank = N/4).

Ports:
- iCLK  in  1  clock.
- iRESET  in  1  reset, synchronous, active-high.
- iSTART  in  1  start pulse; accepted only in IDLE.
- iLOG2N  in  4  log2 of transform length; latched on accepted start.
- iHOLD  in  1  stall; freezes all sequencing while high.
- oRDY  out  1  high in IDLE.
- oDONE  out  1  one-cycle pulse when the last stage drains.
- oSTAGE  out  4  current stage index s.
- oST_ZERO  out  1  s==0 and running.
- oST_LAST  out  1  s==L-1 and running.
- oADDR_RD_A  out  A_BIT  read address, banks 0/2.
- oADDR_RD_B  out  A_BIT  read address, banks 1/3.
- oADDR_WR_A  out  A_BIT  write address, banks 0/2.
- oADDR_WR_B  out  A_BIT  write address, banks 1/3.
- oADDR_COEF  out  A_BIT  coefficient ROM address.
- oRD_VALID  out  1  read addresses valid this cycle.
- oWE_A  out  1  write enable, bank set A.
- oWE_B  out  1  write enable, bank set B.
- oSOURCE_DATA  out  1  ping-pong data source select.

Behaviour:
- Reset values: oRDY=1; oSTAGE, all addresses, oWE_A, oWE_B, oRD_VALID, oDONE, oSOURCE_DATA = 0.
- Length selection: L = iLOG2N latched on start, clamped to [3, LOG2N_MAX]. Bank depth D = 2^(L-2).
- FSM states: IDLE -> RUN (iSTART) -> DRAIN (cnt==D-1 issued) -> RUN (next stage) or DONE (s==L-1) -> IDLE.
  - DONE lasts 1 cycle and raises oDONE; oRDY rises the same cycle.
  - iSTART in any state other than IDLE is ignored.
- RUN phase:
  - cnt steps 0..D-1, one per cycle; oRD_VALID=1.
  - oADDR_RD_A = cnt.
  - sub = 2^(s-1) for s>=2. oADDR_RD_B = cnt for s<2, else (cnt & ~(sub-1)) | ((sub - (cnt & (sub-1))) & (sub-1)) (Hartley mirror).
  - oADDR_COEF = (cnt & (sub-1)) << (LOG2N_MAX-1-s) for s>=2, else 0.
- DRAIN phase: exactly PIPE_LAT cycles with oRD_VALID=0. Then s increments, cnt clears, oSOURCE_DATA toggles.
- Write path:
  - The read address pair and a valid bit pass through a PIPE_LAT-deep delay line to oADDR_WR_A/B.
  - Write enable equals the delayed valid, steered to oWE_B on even stages and oWE_A on odd stages; the other enable is 0.
  - Write addresses are held at 0 when the delayed valid is 0.
- Stage duration is D+PIPE_LAT cycles; total run is L*(D+PIPE_LAT) cycles plus 1 DONE cycle.
- iHOLD:
  - Freezes the FSM, cnt, stage, delay line and oSOURCE_DATA.
  - Forces oWE_A=oWE_B=0 and oRD_VALID=0; addresses hold their values.
  - Release resumes the sequence exactly where it stopped.
  - iHOLD in IDLE has no effect; iSTART while IDLE with iHOLD=1 is accepted, and the first read occurs after release.
- Arithmetic: all address arithmetic is modulo 2^A_BIT. The mirror expression never exceeds D-1.
- Reset mid-operation: returns to reset values on the next edge; no oDONE pulse is generated.

Decomposition:
- Shared package fht_pkg holds:
  - the FSM state enum (IDLE, RUN, DRAIN, DONE);
  - LOG2N_MIN=3;
  - the mirror-address function;
  - the clamp function for L.
- One sub-module, fht_delay_line (width, depth; hold-enable; synchronous clear), implements the write-address/valid pipeline.

Test Plan:
- LOG2N_MAX=10, PIPE_LAT=3, iLOG2N=4, single start:
  - D=4, 4 stages of 7 cycles.
  - oDONE pulses 29 cycles after the start is accepted; oRDY low in between.
  - oSOURCE_DATA toggles 3 times.
- Same run, stage 3:
  - oADDR_RD_B sequence 0,3,2,1.
  - oADDR_COEF sequence 0,64,128,192.
  - Writes occur on oWE_A with oADDR_WR_B 0,3,2,1 appearing 3 cycles after the reads.
- Stage 0 of the same run: oWE_B asserted 4 cycles with oADDR_WR_A = oADDR_WR_B = 0,1,2,3; oST_ZERO=1 throughout.
- iHOLD high for 5 cycles mid-RUN in stage 2:
  - All outputs frozen, WE=0.
  - Total run extends by exactly 5 cycles.
  - Address sequences are identical to the unstalled run.
- iLOG2N=15, then iLOG2N=1:
  - 15 clamps to L=10 (D=256, 10 stages).
  - 1 clamps to L=3 (D=2, 3 stages, 15-cycle run + DONE).
- iRESET asserted in stage 1, and iSTART repeated while busy:
  - Reset returns all outputs to reset values next cycle, with no oDONE.
  - The repeated start does not restart the sequence.
